// File: rtl/tensor_vector_packer_pkg.sv
// Shared defaults and the per-bank state encoding for tensor_vector_packer.
package tensor_vector_packer_pkg;

  localparam int unsigned NPU_ELEM_W     = 16;
  localparam int unsigned NPU_VEC_LEN    = 64;
  localparam int unsigned NPU_PACK_LANES = 4;

  typedef enum logic [0:0] {
    StFill,
    StHold
  } tvp_state_e;

endpackage

// File: rtl/tensor_vector_packer_if.sv
// Beat-in / vector-out handshake bundle of tensor_vector_packer.
interface tensor_vector_packer_if
  import tensor_vector_packer_pkg::*;
#(
  parameter int unsigned ELEM_W  = NPU_ELEM_W,
  parameter int unsigned VEC_LEN = NPU_VEC_LEN,
  parameter int unsigned LANES   = NPU_PACK_LANES
);

  logic [LANES*ELEM_W-1:0]   in_data;
  logic [LANES-1:0]          in_keep;
  logic                      in_last;
  logic                      in_valid;
  logic                      in_ready;
  logic [VEC_LEN*ELEM_W-1:0] out_data;
  logic [$clog2(VEC_LEN):0]  out_count;
  logic                      out_last;
  logic                      out_valid;
  logic                      out_ready;
  logic                      err;

  modport master (
    output in_data, in_keep, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_count, out_last, out_valid, err
  );

  modport slave (
    input  in_data, in_keep, in_last, in_valid, out_ready,
    output in_ready, out_data, out_count, out_last, out_valid, err
  );

endinterface

// File: rtl/tensor_vector_packer_bank.sv
// One vector storage bank: write pointer, close detection, element count and last flag.
module tensor_vector_packer_bank
  import tensor_vector_packer_pkg::*;
#(
  parameter int unsigned ELEM_W  = NPU_ELEM_W,
  parameter int unsigned VEC_LEN = NPU_VEC_LEN,
  parameter int unsigned LANES   = NPU_PACK_LANES
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_en_i,
  input  logic [LANES*ELEM_W-1:0]       wr_data_i,
  input  logic [$clog2(LANES+1)-1:0]    wr_cnt_i,
  input  logic                          wr_last_i,
  input  logic                          drain_i,
  output logic                          free_o,
  output logic                          closed_o,
  output logic                          close_o,
  output logic [VEC_LEN*ELEM_W-1:0]     data_o,
  output logic [$clog2(VEC_LEN):0]      count_o,
  output logic                          last_o
);

  localparam int unsigned AddrW = $clog2(VEC_LEN);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned CntW  = $clog2(LANES + 1);
  localparam logic [PtrW-1:0] VecLenP = PtrW'(VEC_LEN);

  tvp_state_e                      state_q, state_d;
  logic [PtrW-1:0]                 ptr_q, ptr_d;
  logic                            last_q, last_d;
  logic [VEC_LEN-1:0][ELEM_W-1:0]  mem_q;
  logic [PtrW-1:0]                 lane_pos [LANES];
  logic [PtrW:0]                   sum;
  logic [PtrW-1:0]                 ptr_sat;
  logic                            wr_fire;
  logic                            closing;

  assign wr_fire = wr_en_i && (state_q == StFill);
  assign sum     = {1'b0, ptr_q} + (PtrW+1)'(wr_cnt_i);
  // Malformed beats can overshoot the vector; clamp so the bank still closes at VEC_LEN.
  assign ptr_sat = (sum > {1'b0, VecLenP}) ? VecLenP : sum[PtrW-1:0];
  assign closing = wr_fire && ((ptr_sat == VecLenP) || (wr_last_i && (ptr_sat != '0)));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    case (state_q)
      StFill: begin
        if (wr_fire) begin
          ptr_d = ptr_sat;
          if (closing) begin
            state_d = StHold;
            last_d  = wr_last_i;
          end
        end
      end
      StHold: begin
        if (drain_i) begin
          state_d = StFill;
          ptr_d   = '0;
          last_d  = 1'b0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StFill;
      ptr_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_pos[k] = ptr_q + PtrW'(k);
    end
  end

  // Storage needs no reset: everything at or beyond the count is masked at the output.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      for (int k = 0; k < LANES; k++) begin
        if ((CntW'(k) < wr_cnt_i) && (lane_pos[k] < VecLenP)) begin
          mem_q[lane_pos[k][AddrW-1:0]] <= wr_data_i[k*ELEM_W +: ELEM_W];
        end
      end
    end
  end

  assign free_o   = (state_q == StFill);
  assign closed_o = (state_q == StHold);
  assign close_o  = closing;
  assign data_o   = mem_q;
  assign count_o  = ptr_q;
  assign last_o   = last_q;

endmodule

// File: rtl/tensor_vector_packer.sv
// Packs LANES-wide element beats into zero-padded VEC_LEN vectors with a sticky protocol error.
// Define TVP_PINGPONG_EN for two alternating banks; otherwise a single bank is used.
module tensor_vector_packer
  import tensor_vector_packer_pkg::*;
#(
  parameter int unsigned ELEM_W  = NPU_ELEM_W,
  parameter int unsigned VEC_LEN = NPU_VEC_LEN,
  parameter int unsigned LANES   = NPU_PACK_LANES
) (
  input  logic                   clk,
  input  logic                   rst,
  tensor_vector_packer_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(VEC_LEN) + 1;
  localparam int unsigned CntW = $clog2(LANES + 1);
  localparam int unsigned VecW = VEC_LEN * ELEM_W;

  logic            accept;
  logic            xfer;
  logic [CntW-1:0] beat_cnt;
  logic            keep_contig;
  logic            beat_bad;
  logic            err_q, err_d;
  logic            sel_closed;
  logic [VecW-1:0] sel_data;
  logic [PtrW-1:0] sel_count;
  logic            sel_last;
  logic [PtrW-1:0] out_count;

  assign accept = bus.in_valid && bus.in_ready;
  assign xfer   = bus.out_valid && bus.out_ready;

  always_comb begin
    beat_cnt    = '0;
    keep_contig = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      beat_cnt += CntW'(bus.in_keep[k]);
    end
    for (int k = 1; k < LANES; k++) begin
      if (bus.in_keep[k] && !bus.in_keep[k-1]) keep_contig = 1'b0;
    end
  end

  // Partial beats are only legal as the final beat of a tensor.
  assign beat_bad = !keep_contig || (!(&bus.in_keep) && !bus.in_last);
  assign err_d    = err_q || (accept && beat_bad);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

`ifdef TVP_PINGPONG_EN
  logic                 fill_sel_q, fill_sel_d;
  logic                 rd_sel_q, rd_sel_d;
  logic [1:0]           bank_free;
  logic [1:0]           bank_closed;
  logic [1:0]           bank_close;
  logic [1:0]           bank_last;
  logic [1:0][VecW-1:0] bank_data;
  logic [1:0][PtrW-1:0] bank_count;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tensor_vector_packer_bank #(
      .ELEM_W  (ELEM_W),
      .VEC_LEN (VEC_LEN),
      .LANES   (LANES)
    ) u_bank (
      .clk_i     (clk),
      .rst_i     (rst),
      .wr_en_i   (accept && (fill_sel_q == 1'(b))),
      .wr_data_i (bus.in_data),
      .wr_cnt_i  (beat_cnt),
      .wr_last_i (bus.in_last),
      .drain_i   (xfer && (rd_sel_q == 1'(b))),
      .free_o    (bank_free[b]),
      .closed_o  (bank_closed[b]),
      .close_o   (bank_close[b]),
      .data_o    (bank_data[b]),
      .count_o   (bank_count[b]),
      .last_o    (bank_last[b])
    );
  end

  // Banks close and drain in the same order, so a toggle per event keeps them paired.
  assign fill_sel_d = fill_sel_q ^ bank_close[fill_sel_q];
  assign rd_sel_d   = rd_sel_q ^ xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_sel_q <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      fill_sel_q <= fill_sel_d;
      rd_sel_q   <= rd_sel_d;
    end
  end

  assign bus.in_ready = bank_free[fill_sel_q];
  assign sel_closed   = bank_closed[rd_sel_q];
  assign sel_data     = bank_data[rd_sel_q];
  assign sel_count    = bank_count[rd_sel_q];
  assign sel_last     = bank_last[rd_sel_q];
`else
  logic bank_free;
  logic unused_close;

  tensor_vector_packer_bank #(
    .ELEM_W  (ELEM_W),
    .VEC_LEN (VEC_LEN),
    .LANES   (LANES)
  ) u_bank (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (accept),
    .wr_data_i (bus.in_data),
    .wr_cnt_i  (beat_cnt),
    .wr_last_i (bus.in_last),
    .drain_i   (xfer),
    .free_o    (bank_free),
    .closed_o  (sel_closed),
    .close_o   (unused_close),
    .data_o    (sel_data),
    .count_o   (sel_count),
    .last_o    (sel_last)
  );

  assign bus.in_ready = bank_free;
`endif

  assign out_count     = sel_closed ? sel_count : '0;
  assign bus.out_valid = sel_closed;
  assign bus.out_count = out_count;
  assign bus.out_last  = sel_closed && sel_last;
  assign bus.err       = err_q;

  // Elements past the count may hold stale data from an earlier vector.
  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      if (PtrW'(i) < out_count) begin
        bus.out_data[i*ELEM_W +: ELEM_W] = sel_data[i*ELEM_W +: ELEM_W];
      end
    end
  end

endmodule
